// File: rtl/uart_pkg.sv
// uart_pkg
//   Constants and helpers shared across the UART receive path.
//   BYTE_W                  - width of one UART character
//   RX_BUF_DEPTH_DEFAULT    - default receive buffer depth (entries)
//   RX_BUF_HEADROOM_DEFAULT - default free slots kept when rts drops
//   ptr_w()                 - FIFO pointer width: index bits plus one wrap bit
package uart_pkg;

  localparam int BYTE_W                  = 8;
  localparam int RX_BUF_DEPTH_DEFAULT    = 16;
  localparam int RX_BUF_HEADROOM_DEFAULT = 4;

  // The extra MSB distinguishes full from empty when the index bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
//   DEPTH x BYTE_W storage array for the receive buffer. One synchronous
//   write port and one combinational read port. Contents are not reset.
//   Ports:
//     clk   - system clock
//     we    - write enable
//     waddr - write index
//     wdata - write byte
//     raddr - read index
//     rdata - byte at raddr (combinational)
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_BUF_DEPTH_DEFAULT,
  parameter int AW    = $clog2(RX_BUF_DEPTH_DEFAULT)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   Circular byte FIFO between the UART receiver and the command logic.
//   Captures bytes on a one-cycle strobe, hands them out over valid/ready,
//   drives rts from the fill level and records dropped bytes.
//   Ports:
//     clk          - system clock, rising edge
//     reset        - asynchronous active-low reset
//     rx_data      - received byte
//     rx_valid     - one-cycle strobe qualifying rx_data
//     m_data       - head byte (8'h00 when empty)
//     m_valid      - head byte present
//     m_ready      - consumer takes the head byte this cycle
//     rts          - 1 = sender may transmit
//     level        - bytes stored, 0..DEPTH
//     overflow     - sticky drop flag
//     clr_overflow - one-cycle clear of overflow and drop_count
//     drop_count   - saturating count of dropped bytes
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH    = RX_BUF_DEPTH_DEFAULT,
  parameter int HEADROOM = RX_BUF_HEADROOM_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        rx_data,
  input  logic                     rx_valid,
  output logic [BYTE_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     rts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [7:0]               drop_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] RTS_THR = PW'(DEPTH - HEADROOM);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic              empty, full;
  logic              rd_en, wr_en, drop;
  logic              rts_q, overflow_q;
  logic [7:0]        drop_count_q;
  logic [BYTE_W-1:0] mem_rdata;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[PW-1] != rd_ptr[PW-1]);

  assign rd_en = !empty && m_ready;
  // A read in the same cycle frees the slot, so a full buffer still accepts.
  assign wr_en = rx_valid && (!full || rd_en);
  assign drop  = rx_valid && full && !rd_en;

  assign wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, wr_en};
  assign rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, rd_en};
  assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rts_q        <= 1'b1;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      // Registered from the next level so rts tracks level in the same cycle.
      rts_q  <= (level_nxt < RTS_THR);
      if (drop) begin
        overflow_q   <= 1'b1;
        // A drop coinciding with a clear restarts the count at one.
        drop_count_q <= clr_overflow ? 8'd1 : sat_inc8(drop_count_q);
      end else if (clr_overflow) begin
        overflow_q   <= 1'b0;
        drop_count_q <= 8'd0;
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign m_valid    = !empty;
  assign m_data     = empty ? '0 : mem_rdata;
  assign level      = wr_ptr - rd_ptr;
  assign rts        = rts_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  localparam int DEPTH    = 16;
  localparam int HEADROOM = 4;
  localparam int THR      = DEPTH - HEADROOM;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       rts;
  logic [4:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic [7:0] drop_count;

  uart_rx_buffer #(
    .DEPTH    (DEPTH),
    .HEADROOM (HEADROOM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .rts          (rts),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of bytes expected out, plus model of flags.
  logic [7:0] sb [$];
  logic       ovf_m;
  int         drop_m;
  logic       rts_m;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    int         lvl;
    logic       mv;
    logic [7:0] md;
    logic       rt;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_model();
    chk("level", int'(level), sb.size());
    chk("m_valid", int'(m_valid), (sb.size() > 0) ? 1 : 0);
    chk("m_data", int'(m_data), (sb.size() > 0) ? int'(sb[0]) : 0);
    chk("rts", int'(rts), int'(rts_m));
    chk("overflow", int'(overflow), int'(ovf_m));
    chk("drop_count", int'(drop_count), drop_m);
  endtask

  // Called at a falling edge: checks state, drives one cycle, updates model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic       full;
    logic       rd;
    logic [7:0] e;
    check_model();
    rx_valid     = v;
    rx_data      = d;
    m_ready      = r;
    clr_overflow = c;
    full = (sb.size() == DEPTH);
    rd   = r && (sb.size() > 0);
    if (rd) begin
      e = sb.pop_front();
      chk("sb_out", int'(m_data), int'(e));
    end
    if (v && (!full || rd)) sb.push_back(d);
    if (v && full && !rd) begin
      ovf_m  = 1'b1;
      drop_m = c ? 1 : ((drop_m < 255) ? drop_m + 1 : 255);
    end else if (c) begin
      ovf_m  = 1'b0;
      drop_m = 0;
    end
    rts_m = (sb.size() < THR);
    @(posedge clk);
    @(negedge clk);
    rx_valid     = 1'b0;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;
    ovf_m        = 1'b0;
    drop_m       = 0;
    rts_m        = 1'b1;

    tbl[0] = '{v:1'b1, d:8'h55, r:1'b0, lvl:1, mv:1'b1, md:8'h55, rt:1'b1};
    tbl[1] = '{v:1'b0, d:8'h00, r:1'b0, lvl:1, mv:1'b1, md:8'h55, rt:1'b1};
    tbl[2] = '{v:1'b0, d:8'h00, r:1'b1, lvl:0, mv:1'b0, md:8'h00, rt:1'b1};
    tbl[3] = '{v:1'b0, d:8'h00, r:1'b1, lvl:0, mv:1'b0, md:8'h00, rt:1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_model();
    reset = 1'b1;

    // Single byte write/read, table driven
    for (int i = 0; i < 4; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      chk("tbl_level", int'(level), tbl[i].lvl);
      chk("tbl_m_valid", int'(m_valid), int'(tbl[i].mv));
      chk("tbl_m_data", int'(m_data), int'(tbl[i].md));
      chk("tbl_rts", int'(rts), int'(tbl[i].rt));
    end

    // Fill to full; rts falls as level reaches 12
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_rts", int'(rts), (i + 1 < THR) ? 1 : 0);
    end
    chk("full_level", int'(level), 16);

    // 17th write is dropped
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("drop_overflow", int'(overflow), 1);
    chk("drop_count1", int'(drop_count), 1);
    chk("drop_level", int'(level), 16);

    // Drain in order; rts rises at level 11
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", int'(m_data), i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_rts", int'(rts), (DEPTH - 1 - i < THR) ? 1 : 0);
    end

    // Refill, then write 0x77 while reading on a full buffer
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("simul_level", int'(level), 16);
    chk("simul_drop_count", int'(drop_count), 1);

    // 300 drops saturate the counter
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'hE0, 1'b0, 1'b0);
    chk("sat_drop_count", int'(drop_count), 255);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_drop_count", int'(drop_count), 0);
    cyc(1'b1, 8'hE1, 1'b0, 1'b1);
    chk("clr_drop_overflow", int'(overflow), 1);
    chk("clr_drop_count", int'(drop_count), 1);

    // Drain; 0x77 must be last
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("last_0x77", int'(m_data), 8'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Streaming: prime 3 bytes, then 40 cycles of write+read
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h83 + i), 1'b1, 1'b0);
      chk("stream_level", int'(level), 3);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Async reset mid-stream at level 7
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("pre_reset_level", int'(level), 7);
    #2 reset = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_rts", int'(rts), 1);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    sb.delete();
    ovf_m  = 1'b0;
    drop_m = 0;
    rts_m  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("post_rst_data", int'(m_data), 8'hC3);
    chk("post_rst_level", int'(level), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
